// File: rtl/seg7_pkg.sv
// Shared definitions for the memory-mapped seven-segment controller: register offsets,
// CTRL field positions, bus access-size encoding, write merge and hex-to-segment decode.
package seg7_pkg;

  localparam logic [63:0] OffData = 64'h0;
  localparam logic [63:0] OffCtrl = 64'h8;

  localparam int unsigned CtrlDpLsb    = 0;
  localparam int unsigned CtrlDpW      = 16;
  localparam int unsigned CtrlEnBit    = 16;
  localparam int unsigned CtrlBlankBit = 17;
  localparam int unsigned CtrlBrtLsb   = 18;
  localparam int unsigned CtrlBrtW     = 4;
  localparam int unsigned CtrlBlinkBit = 22;

  typedef enum logic [1:0] {
    SzByte  = 2'b00,
    SzHalf  = 2'b01,
    SzWord  = 2'b10,
    SzDword = 2'b11
  } size_e;

  // Replace the low 8/16/32/64 bits of a register, keeping the rest.
  function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                              input logic [63:0] wr_val,
                                              input size_e       sz);
    logic [63:0] res;
    res = old_val;
    case (sz)
      SzByte:  res[7:0]  = wr_val[7:0];
      SzHalf:  res[15:0] = wr_val[15:0];
      SzWord:  res[31:0] = wr_val[31:0];
      default: res       = wr_val;
    endcase
    return res;
  endfunction

  // Active-high segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Scan timing for the seven-segment controller: slot divider, digit index, PWM window and
// blink phase. The blink counter exists only when SEG7_BLINK_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 1024,
  parameter int unsigned BLINK_DIV = 2**23,
  localparam int unsigned IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CtrlBrtW-1:0] bright_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                pwm_on_o,
  output logic                blink_phase_o
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned Step = SCAN_DIV / 16;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 16 || SCAN_DIV < 16 || (SCAN_DIV % 16) != 0 ||
      BLINK_DIV < 1) begin : g_bad_param
    $error("seg7_scan: illegal DIGITS/SCAN_DIV/BLINK_DIV");
  end

  logic [DivW-1:0] div_q, div_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [DivW:0]   thresh;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivMax) begin
      div_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Lit window is (b+1)/16 of the slot, starting at the slot boundary.
  always_comb begin
    thresh   = (DivW + 1)'((32'(bright_i) + 32'd1) * Step);
    pwm_on_o = ({1'b0, div_q} < thresh);
  end

  assign idx_o = idx_q;

`ifdef SEG7_BLINK_EN
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_DIV - 1);

  logic [BlkW-1:0] blk_q, blk_d;
  logic            phase_q, phase_d;

  always_comb begin
    blk_d   = blk_q + 1'b1;
    phase_d = phase_q;
    if (blk_q == BlkMax) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      blk_q   <= blk_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase_o = phase_q;
`else
  assign blink_phase_o = 1'b0;
`endif

endmodule

// File: rtl/seg7_mmio_ctrl.sv
// Memory-mapped seven-segment display controller: DATA/CTRL registers on the data bus,
// two-stage scan pipeline to the pins. Define SEG7_BLINK_EN to build the blink feature.
module seg7_mmio_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter logic [63:0] BASE_ADDR      = 64'h1024,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned BLINK_DIV      = 2**23,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       daddr,
  input  logic [63:0]       wdata,
  input  logic              rw,
  input  logic [1:0]        word,
  output logic [63:0]       rdata,
  output logic [6:0]        seg7_out,
  output logic              seg7dp_out,
  output logic [DIGITS-1:0] seg7_sel
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] DataMask =
      (DIGITS >= 16) ? '1 : ((64'd1 << (4 * DIGITS)) - 64'd1);
`ifdef SEG7_BLINK_EN
  localparam logic [63:0] CtrlMask = 64'h7F_FFFF;
`else
  localparam logic [63:0] CtrlMask = 64'h3F_FFFF;
`endif
  localparam logic [6:0]        InvSeg = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] InvSel = {DIGITS{SEG_ACTIVE_LOW}};

  // ---------------------------------------------------------------------------
  // Register file and bus decode
  // ---------------------------------------------------------------------------
  logic [63:0] data_q, data_d;
  logic [63:0] ctrl_q, ctrl_d;
  logic [63:0] rdata_q, rdata_d;
  logic        hit_data, hit_ctrl;

  assign hit_data = (daddr == BASE_ADDR + OffData);
  assign hit_ctrl = (daddr == BASE_ADDR + OffCtrl);

  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    rdata_d = '0;
    if (rw) begin
      if (hit_data) data_d = merge_write(data_q, wdata, size_e'(word)) & DataMask;
      if (hit_ctrl) ctrl_d = merge_write(ctrl_q, wdata, size_e'(word)) & CtrlMask;
    end else begin
      if (hit_data)      rdata_d = data_q;
      else if (hit_ctrl) rdata_d = ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] scan_idx;
  logic            pwm_on;
  logic            blink_phase;

  seg7_scan #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_scan (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .bright_i      (ctrl_q[CtrlBrtLsb +: CtrlBrtW]),
    .idx_o         (scan_idx),
    .pwm_on_o      (pwm_on),
    .blink_phase_o (blink_phase)
  );

  // ---------------------------------------------------------------------------
  // Stage 1: pick nibble, blank and dp for the scanned digit
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] keep;

  // keep[i] is set when digit i sits at or below the highest nonzero nibble.
  always_comb begin
    logic seen;
    seen = 1'b0;
    keep = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      seen    = seen | (data_q[4*i +: 4] != 4'h0);
      keep[i] = seen;
    end
    keep[0] = 1'b1;
  end

  logic [IdxW-1:0] s1_idx_q, s1_idx_d;
  logic [3:0]      s1_nib_q, s1_nib_d;
  logic            s1_lit_q, s1_lit_d;
  logic            s1_blank_q, s1_blank_d;
  logic            s1_dp_q, s1_dp_d;

  always_comb begin
    s1_idx_d   = scan_idx;
    s1_nib_d   = data_q[{scan_idx, 2'b00} +: 4];
    s1_dp_d    = ctrl_q[CtrlDpLsb + 32'(scan_idx)];
    s1_blank_d = ctrl_q[CtrlBlankBit] & ~keep[scan_idx];
    s1_lit_d   = ctrl_q[CtrlEnBit] & pwm_on & ~(ctrl_q[CtrlBlinkBit] & blink_phase);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_idx_q   <= '0;
      s1_nib_q   <= '0;
      s1_lit_q   <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_dp_q    <= 1'b0;
    end else begin
      s1_idx_q   <= s1_idx_d;
      s1_nib_q   <= s1_nib_d;
      s1_lit_q   <= s1_lit_d;
      s1_blank_q <= s1_blank_d;
      s1_dp_q    <= s1_dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decode and register the pins (reset drives them inactive at once)
  // ---------------------------------------------------------------------------
  logic [6:0]        seg_act;
  logic              dp_act;
  logic [DIGITS-1:0] sel_act;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] sel_q;

  always_comb begin
    seg_act = 7'h00;
    sel_act = '0;
    if (s1_lit_q && !s1_blank_q) seg_act = hex_to_seg(s1_nib_q);
    sel_act[s1_idx_q] = s1_lit_q;
    dp_act = s1_lit_q & s1_dp_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= InvSeg;
      dp_q  <= SEG_ACTIVE_LOW;
      sel_q <= InvSel;
    end else begin
      seg_q <= seg_act ^ InvSeg;
      dp_q  <= dp_act ^ SEG_ACTIVE_LOW;
      sel_q <= sel_act ^ InvSel;
    end
  end

  assign seg7_out   = seg_q;
  assign seg7dp_out = dp_q;
  assign seg7_sel   = sel_q;

endmodule

// File: doc/seg7_mmio_ctrl.md
# seg7_mmio_ctrl

Memory-mapped, parametrised seven-segment display controller on the CPU data bus. It replaces the fixed 4-digit latch-plus-display pair with a registered peripheral. Features: N digits, read-back, per-digit decimal points, leading-zero blanking, PWM brightness and optional blink. It decodes its own address window from the data-side bus signals (daddr/wdata/rw/word) and drives the board's segment and select pins directly.

## Interface
- DIGITS, 4: number of digits, 1..16; data register holds 4*DIGITS bits.
- BASE_ADDR, 64'h1024: byte address of DATA register; CTRL at BASE_ADDR+8.
- SCAN_DIV, 1024: clk cycles per digit slot; must be a multiple of 16 and ≥16.
- BLINK_DIV, 2**23: clk cycles per blink half-period (blink build only).
- SEG_ACTIVE_LOW, 1: 1 = segment, dp and select outputs are active-low.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- daddr  in  64  data-bus byte address.
- wdata  in  64  write data.
- rw  in  1  1 = write, 0 = read.
- word  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- rdata  out  64  registered read data.
- seg7_out  out  7  segments, bit0 = a … bit6 = g.
- seg7dp_out  out  1  decimal point of the active digit.
- seg7_sel  out  DIGITS  digit select, one-hot when lit.

## Operation
- Registers:
  - DATA (BASE_ADDR): nibble i = hex value of digit i; digit 0 is rightmost.
  - CTRL (BASE_ADDR+8): [15:0] dp mask (bit i = dp of digit i, upper bits ignored when DIGITS<16); [16] enable; [17] leading-zero blank; [21:18] brightness; [22] blink.
- Write: daddr equal to a register address with rw=1 updates that register's low 8/16/32/64 bits per word. Upper bits are preserved. DATA bits ≥4*DIGITS are never stored.
- Read: rw=0 at a register address loads rdata with its zero-extended contents on the next clk. Any other address loads 0. Unimplemented bits read 0.
- Decode: 0-F hex map (a..g); blanked digit drives all segments off.
- Scan: divider counts 0..SCAN_DIV-1. At wrap, digit index advances 0→DIGITS-1→0.
- Brightness b: select and segments are lit only while divider < (b+1)*SCAN_DIV/16. b=15 gives full duty.
- Leading-zero blank: digits above the highest nonzero nibble are dark. Digit 0 is always lit when DATA=0. Dp still shows on blanked digits.
- enable=0: all outputs inactive. Counters keep running.
- Two-stage scan pipeline: stage 1 selects nibble/blank/dp, stage 2 registers decoded pins.

## Timing
- Reset values:
  - DATA=0; CTRL=0 (display disabled); rdata=0; counters=0.
  - All pins inactive: seg7_out=7'h7F, seg7_sel all-ones, seg7dp_out=1 with SEG_ACTIVE_LOW=1.
- A write at edge k is visible on pins at edge k+2 if the scan is on the written digit.
- Read latency is 1 cycle. Simultaneous write and read are impossible (single rw).
- Digit index changes and select changes occur on the same registered edge. No overlap of two select bits at any cycle.
- Reset assertion mid-scan forces pins inactive asynchronously. Scan restarts at digit 0 after release.

## Configuration
- SEG7_BLINK_EN defined: blink counter present. When CTRL[22]=1, the display is dark during odd BLINK_DIV half-periods. Counter resets to the lit phase.
- SEG7_BLINK_EN undefined: no blink counter; CTRL[22] is not stored and reads 0.

## Structure
- Package seg7_pkg: register offsets, CTRL bit-position constants, word-size encoding constants, hex→segment function.
- Sub-module seg7_scan: divider, digit index, PWM compare, blink phase. Top holds registers, bus decode and pin stage.

## Test plan
- Reset: hold reset_n=0 → seg7_out=7'h7F, seg7_sel=4'hF, rdata=0. Release: unchanged until CTRL written.
- Half write DATA=16'h12AB, CTRL word write 32'h0007_0005 (enable, blank, brightness 1, dp on digits 0 and 2) → scan shows B,A,2,1 with dp on digits 0 and 2. Each digit is lit 2*SCAN_DIV/16 cycles per slot.
- Leading-zero: DATA=16'h0030, CTRL enable+blank → digits 3 and 2 dark, digit 1 shows 3, digit 0 shows 0. DATA=0 → only digit 0 shows 0.
- Read-back: byte write 8'hFF to CTRL after 32'h003C_0001 → read returns 64'h003C_00FF (bit 22 clear). Read at BASE_ADDR+16 returns 0.
- Reset mid-scan at digit 2 → pins inactive within the reset cycle. After release, the first lit digit is 0.
- SEG7_BLINK_EN build, BLINK_DIV=32, CTRL blink set → display dark for 32 cycles after every 32 lit cycles. Non-blink build: CTRL[22] reads 0.
